// File: rtl/tone_sequencer.sv
// Note-by-note square-wave buzzer sequencer: accepts (note, octave, duration) requests,
// plays the tone for the requested milliseconds, then inserts a short silent gap.
module tone_sequencer #(
    parameter int CNT_W        = 32,
    parameter int DUR_W        = 16,
    parameter int MS_TICKS     = 100000,
    parameter int PERIOD_SHIFT = 0,
    parameter int GAP_MS       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note,
    input  logic [1:0]       octave,
    input  logic [DUR_W-1:0] duration,
    output logic             speaker,
    output logic             busy,
    output logic             note_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(MS_TICKS - 1);
    localparam logic [DUR_W-1:0] GAP_LIM   = DUR_W'(GAP_MS);

    // Base half-periods in clk cycles at 100 MHz for do..si; anything else is silent.
    function automatic logic [CNT_W-1:0] half_period(input logic [3:0] n, input logic [1:0] oct);
        logic [CNT_W-1:0] base;
        base = '0;
        case (n)
            4'd1:    base = CNT_W'(381680);
            4'd2:    base = CNT_W'(340136);
            4'd3:    base = CNT_W'(303030);
            4'd4:    base = CNT_W'(285714);
            4'd5:    base = CNT_W'(255102);
            4'd6:    base = CNT_W'(227273);
            4'd7:    base = CNT_W'(202429);
            default: base = '0;
        endcase
        base = base >> PERIOD_SHIFT;
        case (oct)
            2'b01:   base = base << 1;
            2'b10:   base = base >> 1;
            default: base = base;
        endcase
        return base;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] hp_cnt;
    logic [DUR_W-1:0] ms_cnt;
    logic [3:0]       note_lat;
    logic [1:0]       oct_lat;
    logic [DUR_W-1:0] dur_lat;

    logic             accept;
    logic             tick_wrap;
    logic [DUR_W-1:0] ms_limit;
    logic             ms_done;
    logic [CNT_W-1:0] hp;
    logic             tone;

    assign note_ready = (state == S_IDLE) && !rst;
    assign busy       = (state != S_IDLE);
    assign accept     = note_valid && note_ready;

    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign ms_limit  = (state == S_PLAY) ? dur_lat : GAP_LIM;
    assign ms_done   = tick_wrap && ((ms_cnt + DUR_W'(1)) == ms_limit);

    // Pitch is derived from the latched fields so input changes mid-note cannot affect it.
    assign hp   = half_period(note_lat, oct_lat);
    assign tone = (note_lat >= 4'd1) && (note_lat <= 4'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            hp_cnt    <= '0;
            ms_cnt    <= '0;
            speaker   <= 1'b0;
            note_done <= 1'b0;
            note_lat  <= '0;
            oct_lat   <= '0;
            dur_lat   <= '0;
        end else begin
            note_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    hp_cnt   <= '0;
                    ms_cnt   <= '0;
                    speaker  <= 1'b0;
                    if (accept) begin
                        note_lat <= note;
                        oct_lat  <= octave;
                        dur_lat  <= duration;
                        if (duration != '0) begin
                            state <= S_PLAY;
                        end else if (GAP_MS > 0) begin
                            state <= S_GAP;
                        end else begin
                            // Zero-length note with no gap completes immediately.
                            note_done <= 1'b1;
                        end
                    end
                end

                S_PLAY: begin
                    if (ms_done) begin
                        tick_cnt <= '0;
                        ms_cnt   <= '0;
                        hp_cnt   <= '0;
                        speaker  <= 1'b0;
                        if (GAP_MS > 0) begin
                            state <= S_GAP;
                        end else begin
                            state     <= S_IDLE;
                            note_done <= 1'b1;
                        end
                    end else begin
                        if (tick_wrap) begin
                            tick_cnt <= '0;
                            ms_cnt   <= ms_cnt + DUR_W'(1);
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end

                        if (!tone) begin
                            hp_cnt  <= '0;
                            speaker <= 1'b0;
                        end else if (hp <= CNT_W'(1)) begin
                            hp_cnt  <= '0;
                            speaker <= ~speaker;
                        end else if (hp_cnt == hp - CNT_W'(1)) begin
                            hp_cnt  <= '0;
                            speaker <= ~speaker;
                        end else begin
                            hp_cnt <= hp_cnt + CNT_W'(1);
                        end
                    end
                end

                S_GAP: begin
                    hp_cnt  <= '0;
                    speaker <= 1'b0;
                    if (ms_done) begin
                        tick_cnt  <= '0;
                        ms_cnt    <= '0;
                        state     <= S_IDLE;
                        note_done <= 1'b1;
                    end else if (tick_wrap) begin
                        tick_cnt <= '0;
                        ms_cnt   <= ms_cnt + DUR_W'(1);
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    tick_cnt <= '0;
                    hp_cnt   <= '0;
                    ms_cnt   <= '0;
                    speaker  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a 10-cycle millisecond, shift of 12 and a 1 ms gap.
module tb_tone_sequencer;

    localparam int CNT_W = 32;
    localparam int DUR_W = 16;
    localparam int GAP_CYC = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             note_valid;
    logic             note_ready;
    logic [3:0]       note;
    logic [1:0]       octave;
    logic [DUR_W-1:0] duration;
    logic             speaker;
    logic             busy;
    logic             note_done;

    int vectors = 0;
    int errors  = 0;

    tone_sequencer #(
        .CNT_W(CNT_W),
        .DUR_W(DUR_W),
        .MS_TICKS(10),
        .PERIOD_SHIFT(12),
        .GAP_MS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note(note),
        .octave(octave),
        .duration(duration),
        .speaker(speaker),
        .busy(busy),
        .note_done(note_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request and let the accepting edge pass; note_valid stays high if hold is set.
    task automatic start_note(input string tag, input logic [3:0] n, input logic [1:0] oct,
                              input int dur, input bit hold);
        note       = n;
        octave     = oct;
        duration   = DUR_W'(dur);
        note_valid = 1'b1;
        check({tag, " ready"}, 32'(note_ready), 32'd1);
        tick();
        if (!hold) note_valid = 1'b0;
    endtask

    // Follow one note from its first busy cycle to its note_done cycle.
    task automatic measure(input string tag, input int hp, input int play_len);
        int   cyc, tog, first, last, gap_hi, early_done, exp_tog;
        logic prev;
        cyc = 0; tog = 0; first = -1; last = -1; gap_hi = 0; early_done = 0;
        prev = 1'b0;
        check({tag, " busy0"}, 32'(busy), 32'd1);
        check({tag, " spk0"}, 32'(speaker), 32'd0);
        while (busy === 1'b1 && cyc < 5000) begin
            if (cyc < play_len) begin
                if (speaker !== prev) begin
                    tog++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end else if (speaker !== 1'b0) begin
                gap_hi++;
            end
            if (note_done !== 1'b0) early_done++;
            prev = speaker;
            tick();
            cyc++;
        end
        exp_tog = (hp == 0 || play_len == 0) ? 0 : (play_len - 1) / hp;
        check({tag, " busy_len"}, 32'(cyc), 32'(play_len + GAP_CYC));
        check({tag, " toggles"}, 32'(tog), 32'(exp_tog));
        check({tag, " first_toggle"}, 32'(first), (exp_tog > 0) ? 32'(hp) : 32'hFFFF_FFFF);
        check({tag, " last_toggle"}, 32'(last), (exp_tog > 0) ? 32'(exp_tog * hp) : 32'hFFFF_FFFF);
        check({tag, " gap_silent"}, 32'(gap_hi), 32'd0);
        check({tag, " no_early_done"}, 32'(early_done), 32'd0);
        check({tag, " done"}, 32'(note_done), 32'd1);
        check({tag, " ready_at_done"}, 32'(note_ready), 32'd1);
    endtask

    task automatic finish_note(input string tag);
        tick();
        check({tag, " done_1cyc"}, 32'(note_done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; note_valid = 1'b0; note = '0; octave = '0; duration = '0;
        tick(); tick(); tick();
        check("rst spk", 32'(speaker), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(note_done), 32'd0);
        check("rst ready", 32'(note_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst ready", 32'(note_ready), 32'd1);
        tick();

        // do, standard octave, 3 ms: half-period 93 is longer than the note, so it stays low
        start_note("do3", 4'd1, 2'b00, 3, 1'b0);
        measure("do3", 93, 30);
        finish_note("do3");

        start_note("do20", 4'd1, 2'b00, 20, 1'b0);
        measure("do20", 93, 200);
        finish_note("do20");

        start_note("la_lo", 4'd6, 2'b01, 25, 1'b0);
        measure("la_lo", 110, 250);
        finish_note("la_lo");

        start_note("la_hi", 4'd6, 2'b10, 10, 1'b0);
        measure("la_hi", 27, 100);
        finish_note("la_hi");

        start_note("rest0", 4'd0, 2'b00, 2, 1'b0);
        measure("rest0", 0, 20);
        finish_note("rest0");

        start_note("rest9", 4'd9, 2'b00, 2, 1'b0);
        measure("rest9", 0, 20);
        finish_note("rest9");

        start_note("dur0", 4'd1, 2'b00, 0, 1'b0);
        measure("dur0", 93, 0);
        finish_note("dur0");

        // Queued pair: inputs switch to the second note while the first is playing.
        start_note("qA", 4'd6, 2'b10, 4, 1'b1);
        note = 4'd1; octave = 2'b01; duration = DUR_W'(20);
        measure("qA", 27, 40);
        check("qA idle_at_done", 32'(busy), 32'd0);
        tick();
        note_valid = 1'b0;
        measure("qB", 186, 200);
        finish_note("qB");

        // Reset in the middle of PLAY while speaker is high and a new request is pending.
        start_note("rstp", 4'd1, 2'b00, 20, 1'b0);
        repeat (100) tick();
        check("rstp spk_hi", 32'(speaker), 32'd1);
        rst = 1'b1;
        note_valid = 1'b1;
        note = 4'd2; duration = DUR_W'(5);
        #1;
        check("rstp ready_in_rst", 32'(note_ready), 32'd0);
        tick();
        check("rstp spk", 32'(speaker), 32'd0);
        check("rstp busy", 32'(busy), 32'd0);
        check("rstp done", 32'(note_done), 32'd0);
        rst = 1'b0;
        note_valid = 1'b0;
        #1;
        check("rstp ready", 32'(note_ready), 32'd1);
        tick();
        check("rstp done_after", 32'(note_done), 32'd0);
        check("rstp still_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
